// File: rtl/cic_interpolator_pkg.sv
// Shared CIC defaults and accumulator sizing.
// Used by both the interpolator and the decimator so the two ends agree.
package cic_interpolator_pkg;

  localparam int CIC_NUM_STAGES = 4;
  localparam int CIC_STG_GSZ    = 8;

  function automatic int cic_acc_width(
    input int isz,
    input int n,
    input int g
  );
    return isz + n * g;
  endfunction

endpackage

// File: rtl/cic_sat_shift.sv
// Arithmetic right shift of the accumulator, then clip to the
// signed output range with a saturation flag.
module cic_sat_shift
  import cic_interpolator_pkg::*;
#(
  parameter int ASZ   = 56,
  parameter int OSZ   = 16,
  parameter int SHIFT = 32
) (
  input  logic signed [ASZ-1:0] din,
  output logic signed [OSZ-1:0] dout,
  output logic                  sat
);

  localparam logic signed [ASZ-1:0] MAXV =
    $signed({{(ASZ-OSZ+1){1'b0}}, {(OSZ-1){1'b1}}});
  localparam logic signed [ASZ-1:0] MINV =
    $signed({{(ASZ-OSZ+1){1'b1}}, {(OSZ-1){1'b0}}});

  logic signed [ASZ-1:0] s;

  assign s = din >>> SHIFT;

  always_comb begin
    dout = s[OSZ-1:0];
    sat  = 1'b0;
    if (s > MAXV) begin
      dout = {1'b0, {(OSZ-1){1'b1}}};
      sat  = 1'b1;
    end else if (s < MINV) begin
      dout = {1'b1, {(OSZ-1){1'b0}}};
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: low-rate combs, zero-stuff, clk-rate integrators,
// then scaled and saturated output register.
module cic_interpolator
  import cic_interpolator_pkg::*;
#(
  parameter int NUM_STAGES = CIC_NUM_STAGES,
  parameter int STG_GSZ    = CIC_STG_GSZ,
  parameter int ISZ        = 24,
  parameter int OSZ        = 16,
  parameter int SHIFT      = (NUM_STAGES-1)*STG_GSZ + (ISZ-OSZ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_clk,
  input  logic signed [ISZ-1:0] in,
  output logic signed [OSZ-1:0] out,
  output logic                  out_valid,
  output logic                  out_sat,
  output logic                  in_overrun
);

  localparam int ASZ = cic_acc_width(ISZ, NUM_STAGES, STG_GSZ);

  logic [NUM_STAGES:0]   comb_ena;
  logic signed [ASZ-1:0] comb_diff [NUM_STAGES+1];
  logic signed [ASZ-1:0] comb_dly  [NUM_STAGES];
  logic signed [ASZ-1:0] integ     [NUM_STAGES];
  logic signed [ASZ-1:0] stuffed;
  logic signed [OSZ-1:0] sat_out;
  logic                  sat_flag;
  logic                  vld0;

  always_ff @(posedge clk) begin
    if (reset) begin
      comb_ena     <= '0;
      comb_diff[0] <= '0;
    end else begin
      comb_ena <= {comb_ena[NUM_STAGES-1:0], in_clk};
      if (in_clk)
        comb_diff[0] <= {{(ASZ-ISZ){in[ISZ-1]}}, in};
    end
  end

  for (genvar j = 1; j <= NUM_STAGES; j++) begin : g_comb
    always_ff @(posedge clk) begin
      if (reset)
        comb_diff[j] <= '0;
      else if (comb_ena[j-1])
        comb_diff[j] <= comb_diff[j-1] - comb_dly[j-1];
    end
  end

  // Each delay holds the previous sample seen by its stage.
  for (genvar j = 0; j < NUM_STAGES; j++) begin : g_dly
    logic en;
    if (j == 0) begin : g_en0
      assign en = in_clk;
    end else begin : g_enn
      assign en = comb_ena[j-1];
    end
    always_ff @(posedge clk) begin
      if (reset)
        comb_dly[j] <= '0;
      else if (en)
        comb_dly[j] <= comb_diff[j];
    end
  end

  assign stuffed = comb_ena[NUM_STAGES] ?
                   comb_diff[NUM_STAGES] : '0;

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_int
    logic signed [ASZ-1:0] add;
    if (i == 0) begin : g_a0
      assign add = stuffed;
    end else begin : g_an
      assign add = integ[i-1];
    end
    always_ff @(posedge clk) begin
      if (reset)
        integ[i] <= '0;
      else
        integ[i] <= integ[i] + add;
    end
  end

  cic_sat_shift #(
    .ASZ   (ASZ),
    .OSZ   (OSZ),
    .SHIFT (SHIFT)
  ) u_sat (
    .din  (integ[NUM_STAGES-1]),
    .dout (sat_out),
    .sat  (sat_flag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_sat   <= 1'b0;
      vld0      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out       <= sat_out;
      out_sat   <= sat_flag;
      vld0      <= 1'b1;
      out_valid <= vld0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      in_overrun <= 1'b0;
    else if (in_clk && |comb_ena[NUM_STAGES-1:0])
      in_overrun <= 1'b1;
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench: two configurations of the interpolator on shared
// clock, reset and strobe; expected values computed by hand.
module tb_cic_interpolator;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_clk = 1'b0;
  logic signed [23:0] in_a = '0;
  logic signed [15:0] in_b = '0;

  logic signed [15:0] out_a, out_b;
  logic val_a, val_b, sat_a, sat_b, ovr_a, ovr_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Impulse/saturation: default growth, no shift
  cic_interpolator #(
    .ISZ(24), .OSZ(16), .SHIFT(0)
  ) u_dut (
    .clk(clk), .reset(reset), .in_clk(in_clk), .in(in_a),
    .out(out_a), .out_valid(val_a), .out_sat(sat_a),
    .in_overrun(ovr_a)
  );

  // DC gain: R=8, gain 8^3 removed by SHIFT=9
  cic_interpolator #(
    .STG_GSZ(3), .ISZ(16), .OSZ(16), .SHIFT(9)
  ) u_dc (
    .clk(clk), .reset(reset), .in_clk(in_clk), .in(in_b),
    .out(out_b), .out_valid(val_b), .out_sat(sat_b),
    .in_overrun(ovr_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    in_clk = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic run_dc(input string tag);
    in_b = 16'sd1000;
    for (int c = 0; c < 64; c++) begin
      in_clk = (c % 8 == 0);
      tick();
      in_clk = 1'b0;
      if (c >= 1) chk({tag, "_valid"}, val_b, 1);
      if (c >= 1 && c <= 8) chk({tag, "_lat0"}, out_b, 0);
      if (c == 9)  chk({tag, "_o9"},  out_b, 1);
      if (c == 10) chk({tag, "_o10"}, out_b, 7);
      if (c == 11) chk({tag, "_o11"}, out_b, 19);
      if (c == 12) chk({tag, "_o12"}, out_b, 39);
      if (c >= 48) begin
        chk({tag, "_dc"}, out_b, 1000);
        chk({tag, "_nosat"}, sat_b, 0);
      end
    end
  endtask

  initial begin
    // 1. reset values
    do_reset(3);
    reset = 1'b1;
    chk("rst_out", out_a, 0);
    chk("rst_valid", val_a, 0);
    chk("rst_sat", sat_a, 0);
    chk("rst_ovr", ovr_a, 0);
    chk("rst_out_b", out_b, 0);
    chk("rst_valid_b", val_b, 0);
    reset = 1'b0;
    tick();
    chk("rel1_valid", val_a, 0);
    tick();
    chk("rel2_valid", val_a, 1);
    chk("idle_out", out_a, 0);

    // 2. impulse
    in_a = 24'sd5;
    in_clk = 1'b1;
    tick();
    in_clk = 1'b0;
    in_a = '0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k < 9) chk("imp_zero", out_a, 0);
      else chk("imp_first", out_a, 5);
    end
    tick();
    chk("imp_second", out_a, 20);

    // 4. saturation, positive then negative
    do_reset(1);
    in_a = 24'sd8388607;
    for (int c = 0; c < 48; c++) begin
      in_clk = (c % 8 == 0);
      tick();
      in_clk = 1'b0;
      if (c == 8) chk("satp_pre", out_a, 0);
      if (c == 9 || c == 40) begin
        chk("satp_out", out_a, 32767);
        chk("satp_flag", sat_a, 1);
      end
    end
    do_reset(1);
    in_a = -24'sd8388608;
    for (int c = 0; c < 48; c++) begin
      in_clk = (c % 8 == 0);
      tick();
      in_clk = 1'b0;
      if (c == 9 || c == 40) begin
        chk("satn_out", out_a, -32768);
        chk("satn_flag", sat_a, 1);
      end
    end
    in_a = '0;

    // 5. overrun
    do_reset(1);
    in_clk = 1'b1;
    tick();
    in_clk = 1'b0;
    chk("ovr_first", ovr_a, 0);
    tick();
    in_clk = 1'b1;
    tick();
    in_clk = 1'b0;
    chk("ovr_set", ovr_a, 1);
    repeat (8) tick();
    in_clk = 1'b1;
    tick();
    in_clk = 1'b0;
    chk("ovr_sticky", ovr_a, 1);
    repeat (8) tick();
    chk("ovr_hold", ovr_a, 1);
    do_reset(1);
    chk("ovr_clr", ovr_a, 0);
    in_clk = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_clk = 1'b0;
    chk("ovr_rst_wins", ovr_a, 0);

    // 3. DC gain
    do_reset(1);
    run_dc("dc");

    // 6. reset mid-stream, then identical response
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_out", out_b, 0);
    chk("mid_valid", val_b, 0);
    chk("mid_sat", sat_b, 0);
    run_dc("dc2");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
